// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: PC and latch enable/flush generation.
// Latency: zero cycles; all controls are combinational from state and the hazards visible this cycle.
// Backpressure: a data-memory miss freezes PC..EX/MEM and bubbles WB until dhit; halt freezes all.
// Optional build macro PIPE_CTRL_PERF_EN adds saturating stall_cnt / flush_cnt outputs.
module pipeline_ctrl (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       ihit,
    input  logic       dhit,
    input  logic       exmem_dreq,
    input  logic       idex_dREN,
    input  logic [4:0] idex_rt,
    input  logic [4:0] ifid_rs,
    input  logic [4:0] ifid_rt,
    input  logic       ex_br_taken,
    input  logic       id_jump,
    input  logic       memwb_halt,
    output logic       pc_en,
    output logic       ifid_en,
    output logic       idex_en,
    output logic       exmem_en,
    output logic       memwb_en,
    output logic       ifid_flush,
    output logic       idex_flush,
    output logic       exmem_flush,
    output logic       memwb_flush,
    output logic       halted
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        HALTED  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic w_dmiss;
    logic w_load_use;
    logic w_mem_stall;

    // A data access in EX/MEM that has not completed this cycle
    assign w_dmiss = exmem_dreq & ~dhit;

    // Register 0 is hard-wired, so a load targeting it can never create a hazard
    assign w_load_use = idex_dREN & (idex_rt != 5'd0) &
                        ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));

    // While waiting in MEMWAIT the EX/MEM latch is frozen, so only dhit matters
    assign w_mem_stall = ((r_state == RUN) & w_dmiss) |
                         ((r_state == MEMWAIT) & ~dhit);

    // State register: async reset returns to RUN from anywhere, including mid-miss
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: miss entry/exit; halt from WB overrides everything and is sticky
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            RUN:     if (w_dmiss) w_next_state = MEMWAIT;
            MEMWAIT: if (dhit)    w_next_state = RUN;
            HALTED:  w_next_state = HALTED;
            default: w_next_state = RUN;
        endcase
        if (memwb_halt) begin
            w_next_state = HALTED;
        end
    end

    // Output decode: memory stall, then branch, load-use, jump, fetch miss, in priority order
    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        halted      = 1'b0;
        if (nRST) begin
            case (r_state)
                RUN, MEMWAIT: begin
                    if (w_mem_stall) begin
                        // Bubble into WB so the frozen MEM instruction is not written back twice
                        memwb_en    = 1'b1;
                        memwb_flush = 1'b1;
                    end else begin
                        pc_en    = 1'b1;
                        ifid_en  = 1'b1;
                        idex_en  = 1'b1;
                        exmem_en = 1'b1;
                        memwb_en = 1'b1;
                        if (ex_br_taken) begin
                            ifid_flush = 1'b1;
                            idex_flush = 1'b1;
                        end else if (w_load_use) begin
                            // Hold the consumer in ID and slip one bubble into EX
                            pc_en      = 1'b0;
                            ifid_en    = 1'b0;
                            idex_flush = 1'b1;
                        end else if (id_jump) begin
                            ifid_flush = 1'b1;
                        end else if (!ihit) begin
                            pc_en      = 1'b0;
                            ifid_flush = 1'b1;
                        end
                    end
                end
                HALTED: begin
                    halted = 1'b1;
                end
                default: begin
                    halted = 1'b0;
                end
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic w_any_flush;
    assign w_any_flush = ifid_flush | idex_flush | exmem_flush | memwb_flush;

    // Saturating stall/flush counters, frozen once the pipeline has halted
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else if (r_state != HALTED) begin
            if (!pc_en && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (w_any_flush && (flush_cnt != 32'hFFFF_FFFF)) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central hazard and sequencing controller for the 5-stage MIPS pipeline. Generates enable/flush pairs for the IF/ID, ID/EX, EX/MEM and MEM/WB latches plus the PC write enable. Resolves load-use hazards, taken branches, jumps, instruction/data memory wait states and the terminal halt. Sits beside the datapath; all latch control decisions are made here and nowhere else.

## Interface
- No parameters.
- CLK  in  1  system clock, rising edge
- nRST  in  1  asynchronous, active-low reset
- ihit  in  1  instruction memory returned valid instruction this cycle
- dhit  in  1  data memory completed EX/MEM access this cycle
- exmem_dreq  in  1  EX/MEM latch holds a load or store (dREN_o | dWEN_o)
- idex_dREN  in  1  ID/EX latch holds a load
- idex_rt  in  5  destination register of the ID/EX load
- ifid_rs, ifid_rt  in  5 each  source registers of the instruction in IF/ID
- ex_br_taken  in  1  branch in EX resolved taken (PC loads target)
- id_jump  in  1  J/JAL/JR decoded in ID (PC loads target)
- memwb_halt  in  1  halt_o of MEM/WB latch
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch/PC update enables
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  synchronous bubble insert
- halted  out  1  sticky, pipeline stopped

## Operation
- States: RUN, MEMWAIT, HALTED (2-bit register). Outputs are combinational from state and inputs.
- Flush has priority over enable at the latch; controller never asserts flush on a latch whose upstream is frozen unless stated below.
- Priority in RUN, highest first:
  1. exmem_dreq & !dhit: all five enables 0, memwb_en=1, memwb_flush=1 (bubble into WB, no duplicate writeback); next state MEMWAIT.
  2. ex_br_taken: all enables 1, ifid_flush=1, idex_flush=1.
  3. Load-use: idex_dREN & idex_rt!=0 & (idex_rt==ifid_rs | idex_rt==ifid_rt): pc_en=0, ifid_en=0, idex_flush=1, exmem/memwb enables 1.
  4. id_jump: all enables 1, ifid_flush=1.
  5. !ihit: pc_en=0, ifid_flush=1, other enables 1.
  6. Otherwise all enables 1, all flushes 0.
- MEMWAIT: same outputs as rule 1 while !dhit; on dhit all enables 1 (rules 2-6 then apply in that cycle) and next state RUN.
- memwb_halt=1 in any state: next state HALTED. HALTED: all enables 0, all flushes 0, halted=1; exits only on nRST.
- Register 0 never triggers load-use.

## Timing
- Reset (nRST low): state RUN; halted=0; flushes 0; enables 0 while nRST low, per RUN rules from first edge after release.
- Zero-cycle latency: controls apply at the same rising edge the hazard is visible.
- Load-use costs exactly 1 bubble; taken branch costs 2; jump costs 1; data miss costs N+0 cycles where N = cycles until dhit.
- Simultaneous data miss and taken branch: miss wins; branch flush applied on the dhit cycle (ex_br_taken held by frozen ID/EX).
- Simultaneous load-use and jump: load-use wins; jump repeats next cycle.
- halted asserts the cycle after memwb_halt is sampled at a rising edge.
- nRST mid-MEMWAIT: immediate return to RUN, counters cleared.

## Configuration
- PIPE_CTRL_PERF_EN defined: adds outputs stall_cnt (32) and flush_cnt (32), saturating at 0xFFFFFFFF, reset 0. stall_cnt +1 each cycle pc_en=0 and state!=HALTED; flush_cnt +1 each cycle any flush asserted; both frozen in HALTED.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Test plan
- lw $2 then add $3,$2,$4 with ihit=dhit=1 -> one cycle pc_en=0, ifid_en=0, idex_flush=1; lw $0 variant -> no stall.
- beq taken (ex_br_taken=1 one cycle) -> ifid_flush=idex_flush=1, pc_en=1 that cycle; 2 bubbles observed.
- exmem_dreq=1, dhit low 3 cycles -> state MEMWAIT, enables 0, memwb_flush=1 for 3 cycles; dhit=1 -> RUN, all enables 1.
- ex_br_taken=1 during data miss -> no flush until dhit cycle, then ifid_flush=idex_flush=1.
- memwb_halt=1 -> halted=1 next cycle, all enables 0 thereafter; nRST low -> halted=0.
- PIPE_CTRL_PERF_EN: 1 load-use + 1 jump + 3-cycle miss -> stall_cnt=4, flush_cnt=5.
